// File: rtl/booth_pkg.sv
// =====================================================================
// booth_pkg: shared states and constants for the Booth controller
// Rev 1.0
// =====================================================================
`default_nettype none

package booth_pkg;

  localparam int BOOTH_N = 5;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LDY    = 3'd1,
    ST_LDS    = 3'd2,
    ST_EVAL   = 3'd3,
    ST_SHIFT  = 3'd4,
    ST_OUT_HI = 3'd5,
    ST_OUT_LO = 3'd6
  } booth_state_t;

endpackage

`default_nettype wire

// File: rtl/booth_iter_counter.sv
// =====================================================================
// booth_iter_counter: iteration counter with clear, increment and last flag
// Rev 1.0
// =====================================================================
`default_nettype none

import booth_pkg::*;

module booth_iter_counter #(
  parameter int N  = BOOTH_N,
  parameter int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CW'(N - 1));

endmodule

`default_nettype wire

// File: rtl/booth_controller.sv
// =====================================================================
// booth_controller: Moore FSM sequencing the radix-2 Booth datapath
// Rev 1.0
// =====================================================================
`default_nettype none

import booth_pkg::*;

module booth_controller #(
  parameter int N = BOOTH_N
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic m1,
  input  logic m0,
  output logic ldy,
  output logic addsub,
  output logic ldf,
  output logic sclrf,
  output logic shf,
  output logic lds,
  output logic shs,
  output logic sel,
  output logic sclrr,
  output logic ldr,
  output logic ready,
  output logic out_valid
);

  booth_state_t state_q;
  booth_state_t state_d;
  logic         cnt_clr;
  logic         cnt_inc;
  logic         cnt_last;

  booth_iter_counter #(
    .N (N)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .last_o (cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign cnt_clr = (state_q == ST_LDY);
  assign cnt_inc = (state_q == ST_SHIFT) && !cnt_last;

  always_comb begin
    state_d   = state_q;
    ldy       = 1'b0;
    addsub    = OP_ADD;
    ldf       = 1'b0;
    sclrf     = 1'b0;
    shf       = 1'b0;
    lds       = 1'b0;
    shs       = 1'b0;
    sel       = 1'b0;
    sclrr     = 1'b0;
    ldr       = 1'b0;
    ready     = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_d = ST_LDY;
        end
      end
      ST_LDY: begin
        ldy     = 1'b1;
        sclrf   = 1'b1;
        sclrr   = 1'b1;
        state_d = ST_LDS;
      end
      ST_LDS: begin
        lds     = 1'b1;
        state_d = ST_EVAL;
      end
      ST_EVAL: begin
        // Bit pair 10 starts a run of ones (subtract), 01 ends one (add).
        if (m1 ^ m0) begin
          ldf    = 1'b1;
          addsub = m1 ? OP_SUB : OP_ADD;
        end
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        shf     = 1'b1;
        shs     = 1'b1;
        ldr     = 1'b1;
        state_d = cnt_last ? ST_OUT_HI : ST_EVAL;
      end
      ST_OUT_HI: begin
        out_valid = 1'b1;
        state_d   = ST_OUT_LO;
      end
      ST_OUT_LO: begin
        sel       = 1'b1;
        out_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_booth_controller.sv
// =====================================================================
// tb_booth_controller: controller driving a behavioural Booth datapath
// Rev 1.0
// =====================================================================
`default_nettype none

module tb_booth_controller;

  localparam int N  = 5;
  localparam int KE = 2 * N + 5;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic m1, m0;
  logic ldy, addsub, ldf, sclrf, shf, lds, shs, sel, sclrr, ldr, ready, out_valid;

  logic [N-1:0]      data_in = '0;
  logic signed [N:0] f_r = '0;
  logic signed [N:0] y_r = '0;
  logic [N-1:0]      s_r = '0;
  logic              r_r = 1'b0;
  logic              ovr_en = 1'b0;
  logic [1:0]        ovr_val = 2'b00;
  logic [N-1:0]      data_out;
  logic [11:0]       vec;

  int total = 0;
  int bad   = 0;

  booth_controller #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .m1        (m1),
    .m0        (m0),
    .ldy       (ldy),
    .addsub    (addsub),
    .ldf       (ldf),
    .sclrf     (sclrf),
    .shf       (shf),
    .lds       (lds),
    .shs       (shs),
    .sel       (sel),
    .sclrr     (sclrr),
    .ldr       (ldr),
    .ready     (ready),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Datapath model; F carries one guard bit so the accumulator never wraps.
  always @(posedge clk) begin
    if (ldy) y_r <= {data_in[N-1], data_in};
    if (sclrf) f_r <= '0;
    else if (ldf) f_r <= addsub ? (f_r - y_r) : (f_r + y_r);
    else if (shf) f_r <= {f_r[N], f_r[N:1]};
    if (lds) s_r <= data_in;
    else if (shs) s_r <= {f_r[0], s_r[N-1:1]};
    if (sclrr) r_r <= 1'b0;
    else if (ldr) r_r <= s_r[0];
  end

  assign m1       = ovr_en ? ovr_val[1] : s_r[0];
  assign m0       = ovr_en ? ovr_val[0] : r_r;
  assign data_out = sel ? s_r : f_r[N-1:0];
  assign vec      = {ready, out_valid, sel, ldy, lds, sclrf, sclrr, ldf, addsub, shf, shs, ldr};

  // Expected strobes for cycle k after the start-sampled edge.
  function automatic logic [11:0] exp_vec(input int k, input logic b1, input logic b0);
    logic [11:0] v;
    v = '0;
    if (k <= 0 || k >= KE) v[11] = 1'b1;
    else if (k == 1) begin v[8] = 1'b1; v[6] = 1'b1; v[5] = 1'b1; end
    else if (k == 2) v[7] = 1'b1;
    else if (k <= 2 * N + 2) begin
      if (((k - 3) % 2) == 0) begin
        v[4] = b1 ^ b0;
        v[3] = b1 & ~b0;
      end else begin
        v[2] = 1'b1; v[1] = 1'b1; v[0] = 1'b1;
      end
    end
    else if (k == 2 * N + 3) v[10] = 1'b1;
    else begin v[10] = 1'b1; v[9] = 1'b1; end
    return v;
  endfunction

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit hold,
                        input int pulse_k, input bit force_eval, input int abort_k,
                        input string tag);
    logic signed [N-1:0] as_v, bs_v;
    int                  av, bv, p;
    logic [2*N-1:0]      pv;
    logic [11:0]         ev;
    int                  waitc;
    as_v = a; bs_v = b;
    av = as_v; bv = bs_v;
    p  = av * bv;
    pv = p[2*N-1:0];
    waitc = 0;
    while (ready !== 1'b1 && waitc < 40) begin
      @(posedge clk); #1;
      waitc++;
    end
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL %s idle_wait ready=%b want=1", tag, ready);
    end
    start = 1'b1;
    for (int k = 1; k <= KE; k++) begin
      @(posedge clk); #1;
      if (!hold) start = (k == pulse_k);
      if (k == 1) data_in = a;
      else if (k == 2) data_in = b;
      else data_in = N'($urandom);
      ev = exp_vec(k, m1, m0);
      total++;
      if (vec !== ev) begin
        bad++;
        $display("FAIL %s strobes k=%0d got=%b want=%b", tag, k, vec, ev);
      end
      if (force_eval && k == 3) begin
        for (int c = 0; c < 4; c++) begin
          logic [1:0] cv;
          logic [1:0] want;
          cv = 2'(c);
          ovr_en = 1'b1; ovr_val = cv; #1;
          want = {cv[1] ^ cv[0], cv[1] & ~cv[0]};
          total++;
          if ({ldf, addsub} !== want) begin
            bad++;
            $display("FAIL %s eval_m1m0=%b ldf,addsub got=%b want=%b", tag, cv, {ldf, addsub}, want);
          end
        end
        ovr_en = 1'b0; #1;
      end
      if (k == 2 * N + 3 || k == 2 * N + 4) begin
        logic [N-1:0] wd;
        wd = (k == 2 * N + 3) ? pv[2*N-1:N] : pv[N-1:0];
        total++;
        if (data_out !== wd) begin
          bad++;
          $display("FAIL %s %0d*%0d data_out k=%0d got=%b want=%b", tag, av, bv, k, data_out, wd);
        end
      end
      if (k == abort_k) begin
        start = 1'b0;
        rst = 1'b1; #1;
        total++;
        if (vec !== 12'b1000_0000_0000) begin
          bad++;
          $display("FAIL %s async_reset got=%b want=%b", tag, vec, 12'b1000_0000_0000);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (vec !== 12'b1000_0000_0000) begin
          bad++;
          $display("FAIL %s idle_after_reset got=%b want=%b", tag, vec, 12'b1000_0000_0000);
        end
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (vec !== 12'b1000_0000_0000) begin
      bad++;
      $display("FAIL reset_hold got=%b want=%b", vec, 12'b1000_0000_0000);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (vec !== 12'b1000_0000_0000) begin
      bad++;
      $display("FAIL reset_idle got=%b want=%b", vec, 12'b1000_0000_0000);
    end
  endtask

  task automatic test_directed();
    run_op(5'b00011, 5'b00101, 1'b0, -1, 1'b0, -1, "p3x5");
    run_op(5'b11101, 5'b00101, 1'b0, -1, 1'b0, -1, "m3x5");
    run_op(5'b10000, 5'b11111, 1'b0, -1, 1'b0, -1, "m16xm1");
    run_op(5'b10000, 5'b10000, 1'b0, -1, 1'b0, -1, "m16xm16");
    run_op(5'b01111, 5'b10000, 1'b0, -1, 1'b0, -1, "p15xm16");
  endtask

  task automatic test_strobes();
    run_op(5'b00110, 5'b01011, 1'b0, -1, 1'b1, -1, "force_eval");
  endtask

  task automatic test_reset_mid();
    run_op(5'b01010, 5'b10101, 1'b0, -1, 1'b0, 8, "abort");
    run_op(5'b11011, 5'b00111, 1'b0, -1, 1'b0, -1, "after_abort");
  endtask

  task automatic test_back_to_back();
    run_op(5'b00111, 5'b11001, 1'b1, -1, 1'b0, -1, "b2b_0");
    run_op(5'b10011, 5'b01101, 1'b1, -1, 1'b0, -1, "b2b_1");
    run_op(5'b11111, 5'b11111, 1'b0, -1, 1'b0, -1, "b2b_2");
    run_op(5'b01001, 5'b00010, 1'b0, 5, 1'b0, -1, "pulse_eval");
    @(posedge clk); #1;
    total++;
    if (vec !== 12'b1000_0000_0000) begin
      bad++;
      $display("FAIL ignored_pulse got=%b want=%b", vec, 12'b1000_0000_0000);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      run_op(N'($urandom), N'($urandom), 1'b0, -1, 1'b0, -1, "rand");
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    test_reset();
    test_directed();
    test_strobes();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/booth_controller.md
# booth_controller

Control unit for the 5-bit radix-2 Booth multiplier datapath. It accepts a start request, sequences the operand loads from the shared `data_in` bus, and runs N add/subtract-then-shift iterations steered by the Booth bit pair (m1, m0). It then presents the 10-bit signed product on `data_out` as high word then low word. It drives every strobe of the datapath and consumes its m0/m1 status, and it connects port-for-port to the datapath at the multiplier top level.

## Interface
- `N`, default 5: operand width; also the iteration count.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; accepted only in IDLE.
- `m1`  in  1  current multiplier LSB (S[0]).
- `m0`  in  1  previous multiplier bit (R).
- `ldy`  out  1  load Y (multiplicand) from data_in.
- `addsub`  out  1  adder operation: 1 computes F−Y, 0 computes F+Y.
- `ldf`  out  1  load F from the adder output.
- `sclrf`  out  1  synchronous clear of F.
- `shf`  out  1  arithmetic right shift of F (sign kept); F[0] goes to S MSB.
- `lds`  out  1  load S (multiplier) from data_in.
- `shs`  out  1  right shift S.
- `sel`  out  1  output mux select: 0 selects F (high word), 1 selects S (low word).
- `sclrr`  out  1  synchronous clear of R.
- `ldr`  out  1  load R from S[0].
- `ready`  out  1  high only in IDLE.
- `out_valid`  out  1  data_out carries a product word this cycle.

## Operation
- Moore FSM with states IDLE, LDY, LDS, EVAL, SHIFT, OUT_HI, OUT_LO. Iteration counter `cnt` is ceil(log2 N) bits wide.
- **IDLE:** `ready`=1. If `start`=1, go to LDY; otherwise stay.
- **LDY:** `ldy`=1, `sclrf`=1, `sclrr`=1, `cnt`←0. The source must hold the multiplicand on `data_in`. Go to LDS.
- **LDS:** `lds`=1. The source must hold the multiplier on `data_in`. Go to EVAL.
- **EVAL:** action depends on (m1, m0):
  - 10: `ldf`=1, `addsub`=1 (subtract).
  - 01: `ldf`=1, `addsub`=0 (add).
  - 00 or 11: no load; `addsub`=0.
  - Go to SHIFT.
- **SHIFT:** `shf`=1, `shs`=1, `ldr`=1 in the same cycle. R captures the pre-shift S[0].
  - If `cnt`=N−1, go to OUT_HI.
  - Otherwise `cnt`←`cnt`+1 and go to EVAL.
- **OUT_HI:** `sel`=0, `out_valid`=1. Go to OUT_LO.
- **OUT_LO:** `sel`=1, `out_valid`=1. Go to IDLE.
- All strobes not listed for a state are 0. `sel` is 0 outside OUT_LO.
- Product is the 2N-bit two's-complement value {F, S}. Overflow is impossible for any operand pair, including −16 × −16 = 256.
- `start` outside IDLE is ignored; no queuing.
- `start` held high through OUT_LO: IDLE lasts exactly one cycle, then the next operation begins.

## Timing
- Reset value: state=IDLE, `cnt`=0, `ready`=1, all other outputs 0.
- Reset asserted mid-operation forces IDLE asynchronously. Datapath register contents are don't-care until the next LDY.
- All outputs decode from registered state only, with no combinational path from `start`. The single exception is that `ldf`/`addsub` in EVAL depend combinationally on m1/m0.
- Latency from the `start`-sampled edge:
  - LDY occupies cycle 1 and LDS cycle 2.
  - EVAL/SHIFT pairs occupy cycles 3 to 2N+2.
  - OUT_HI is cycle 2N+3 and OUT_LO is cycle 2N+4.
  - For N=5: 14 cycles per product, and `ready` reasserts at cycle 15.
- m1/m0 are sampled in EVAL, one cycle after the previous SHIFT edge, so they are stable.

## Structure
- Shared package `booth_pkg`: state enum `booth_state_t`, constant `BOOTH_N = 5`, and the `addsub` encoding constants `OP_ADD = 0` and `OP_SUB = 1`.
- One sub-module, `booth_iter_counter`: N-iteration counter with synchronous clear, increment enable, and `last` flag (`cnt`=N−1). It is reset asynchronously with `rst`.
- The FSM and output decode live in `booth_controller` itself.

## Test plan
The bench instantiates the controller connected to the datapath and drives `data_in` per the LDY/LDS timing.
- 3 × 5 → OUT_HI `data_out`=00000, OUT_LO `data_out`=01111 (15). Exactly 14 cycles, then `ready`=1.
- −3 × 5 (11101, 00101) → 11111 then 10001 (−15). Separately, −16 × −1 → 00000 then 10000 (16).
- Strobe check: force m1m0=10 in EVAL → `ldf`=1, `addsub`=1. Force 01 → `ldf`=1, `addsub`=0. Force 00 and 11 → `ldf`=0.
- Assert `rst` during the third SHIFT → state IDLE immediately, all strobes 0, `ready`=1. A new `start` then yields a correct product.
- Hold `start`=1 continuously → products back-to-back, with `ready` high exactly one cycle between OUT_LO and the next LDY. A `start` pulse during EVAL is ignored.
